// File: rtl/voice_scheduler.sv
// Shares one sample ROM among NVOICE drum voices, fetching one byte per active voice per frame
// and emitting a saturated signed mix. Optional per-voice gain: define VOICE_SCHED_GAIN_EN.
module voice_scheduler #(
  parameter int NVOICE     = 4,
  parameter int VOFF_W     = 12,
  parameter int VLEN       = 4000,
  parameter int SAMPLE_DIV = 128,
  parameter int ADDR_W     = $clog2(NVOICE) + VOFF_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NVOICE-1:0]     trig,
`ifdef VOICE_SCHED_GAIN_EN
  input  logic [2*NVOICE-1:0]   gain,
`endif
  output logic                  mem_rd,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic [7:0]            mem_data,
  output logic [7:0]            mix_out,
  output logic                  mix_valid,
  output logic [NVOICE-1:0]     busy
);

  localparam int VW = $clog2(NVOICE);
  localparam int TW = $clog2(SAMPLE_DIV);
  localparam int AW = 8 + VW;
  localparam logic signed [AW-1:0] SAT_MAX = AW'(127);
  localparam logic signed [AW-1:0] SAT_MIN = AW'(-128);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPT, OUT} state_t;

  state_t                  state_reg, state_next;
  logic [VW-1:0]           voice_reg, voice_next;
  logic [TW-1:0]           tick_reg;
  logic signed [AW-1:0]    acc_reg;
  logic signed [AW-1:0]    acc_sum;
  logic signed [7:0]       sample_s;
  logic [7:0]              mix_clamped;
  logic [7:0]              mix_reg;
  logic                    mix_valid_reg;
  logic [ADDR_W-1:0]       addr_reg;
  logic [NVOICE-1:0]       trig_reg;
  logic [NVOICE-1:0]       trig_edge;
  logic                    pending_reg [NVOICE];
  logic                    busy_reg    [NVOICE];
  logic [VOFF_W-1:0]       pos_reg     [NVOICE];
  logic                    last_voice;
  logic                    frame_start;

  assign last_voice  = (voice_reg == VW'(NVOICE - 1));
  assign frame_start = (state_reg == IDLE) && (tick_reg == '0);
  assign trig_edge   = trig & ~trig_reg;

  always_comb begin
    state_next = state_reg;
    voice_next = voice_reg;
    case (state_reg)
      IDLE:  if (tick_reg == '0) begin
               state_next = ISSUE;
               voice_next = '0;
             end
      ISSUE: state_next = CAPT;
      CAPT:  if (last_voice) begin
               state_next = OUT;
             end else begin
               state_next = ISSUE;
               voice_next = voice_reg + 1'b1;
             end
      OUT:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Address is live during ISSUE and otherwise holds the last issued value.
  always_comb begin
    mem_rd   = 1'b0;
    mem_addr = addr_reg;
    if (state_reg == ISSUE) begin
      mem_rd   = busy_reg[voice_reg];
      mem_addr = {voice_reg, pos_reg[voice_reg]};
    end
  end

  always_comb begin
    sample_s = $signed(mem_data);
`ifdef VOICE_SCHED_GAIN_EN
    sample_s = $signed(mem_data) >>> gain[{voice_reg, 1'b0} +: 2];
`endif
    acc_sum = acc_reg + (busy_reg[voice_reg] ? {{VW{sample_s[7]}}, sample_s} : '0);
    if (acc_sum > SAT_MAX)      mix_clamped = 8'h7F;
    else if (acc_sum < SAT_MIN) mix_clamped = 8'h80;
    else                        mix_clamped = acc_sum[7:0];
  end

  // The mix is registered on the last CAPT so mix_out and mix_valid are both live during OUT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      voice_reg     <= '0;
      tick_reg      <= '0;
      acc_reg       <= '0;
      mix_reg       <= '0;
      mix_valid_reg <= 1'b0;
      addr_reg      <= '0;
      trig_reg      <= '0;
    end else begin
      state_reg     <= state_next;
      voice_reg     <= voice_next;
      tick_reg      <= (tick_reg == TW'(SAMPLE_DIV - 1)) ? '0 : tick_reg + 1'b1;
      trig_reg      <= trig;
      mix_valid_reg <= 1'b0;
      if (frame_start)
        acc_reg <= '0;
      if (state_reg == ISSUE)
        addr_reg <= mem_addr;
      if (state_reg == CAPT) begin
        acc_reg <= acc_sum;
        if (last_voice) begin
          mix_reg       <= mix_clamped;
          mix_valid_reg <= 1'b1;
        end
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NVOICE; gi++) begin : g_voice
      // A pending retrigger outranks end-of-sample so the voice restarts instead of stopping.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          pending_reg[gi] <= 1'b0;
          busy_reg[gi]    <= 1'b0;
          pos_reg[gi]     <= '0;
        end else if (state_reg == OUT) begin
          pending_reg[gi] <= trig_edge[gi];
          if (pending_reg[gi]) begin
            busy_reg[gi] <= 1'b1;
            pos_reg[gi]  <= '0;
          end else if (busy_reg[gi] && (pos_reg[gi] == VOFF_W'(VLEN - 1))) begin
            busy_reg[gi] <= 1'b0;
            pos_reg[gi]  <= '0;
          end else if (busy_reg[gi]) begin
            pos_reg[gi]  <= pos_reg[gi] + 1'b1;
          end
        end else if (trig_edge[gi]) begin
          pending_reg[gi] <= 1'b1;
        end
      end
      assign busy[gi] = busy_reg[gi];
    end
  endgenerate

  assign mix_out   = mix_reg;
  assign mix_valid = mix_valid_reg;

endmodule

// File: tb/tb_voice_scheduler.sv
// Self-checking bench for voice_scheduler: ROM model, per-frame reference mix, directed and random triggers.
module tb_voice_scheduler;
  localparam int NV     = 4;
  localparam int VOFF_W = 12;
  localparam int VLEN   = 20;
  localparam int SD     = 16;
  localparam int AW     = 14;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NV-1:0] trig = '0;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_data = '0;
  logic [7:0]    mix_out;
  logic          mix_valid;
  logic [NV-1:0] busy;
`ifdef VOICE_SCHED_GAIN_EN
  logic [2*NV-1:0] gain = '0;
`endif

  always #5 clk = ~clk;

  voice_scheduler #(
    .NVOICE(NV), .VOFF_W(VOFF_W), .VLEN(VLEN), .SAMPLE_DIV(SD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .trig(trig),
`ifdef VOICE_SCHED_GAIN_EN
    .gain(gain),
`endif
    .mem_rd(mem_rd),
    .mem_addr(mem_addr),
    .mem_data(mem_data),
    .mix_out(mix_out),
    .mix_valid(mix_valid),
    .busy(busy)
  );

  logic [7:0]    rom [0:(1<<AW)-1];
  logic [AW-1:0] rd_q [$];
  int            cyc = 0;

  always @(posedge clk) if (mem_rd) mem_data <= rom[mem_addr];
  always @(negedge clk) if (!rst && mem_rd) rd_q.push_back(mem_addr);
  always @(posedge clk) cyc <= cyc + 1;

  // Reference state: which voices play, where they are, and triggers awaiting the next frame end.
  bit            m_act  [NV];
  int            m_pos  [NV];
  bit            m_pend [NV];
  logic [NV-1:0] m_trig = '0;
  int            prev_cyc = -1;
  int            total = 0;
  int            bad = 0;
  int            frame_no = 0;
  bit            rand_gain = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_mix();
    int s = 0;
    int d;
    for (int v = 0; v < NV; v++) begin
      if (m_act[v]) begin
        d = $signed(rom[v * (1 << VOFF_W) + m_pos[v]]);
`ifdef VOICE_SCHED_GAIN_EN
        d = d >>> gain[2*v +: 2];
`endif
        s += d;
      end
    end
    if (s > 127)  s = 127;
    if (s < -128) s = -128;
    return 8'(s);
  endfunction

  function automatic logic [NV-1:0] model_busy();
    logic [NV-1:0] b = '0;
    for (int v = 0; v < NV; v++) b[v] = m_act[v];
    return b;
  endfunction

  task automatic model_reset();
    for (int v = 0; v < NV; v++) begin
      m_act[v] = 0; m_pos[v] = 0; m_pend[v] = 0;
    end
    m_trig = '0;
  endtask

  task automatic wait_valid();
    for (int n = 0; n < 3 * SD; n++) begin
      @(negedge clk);
      if (mix_valid) return;
    end
    total++; bad++;
    $error("FAIL valid_timeout observed=0 expected=1");
  endtask

  task automatic check_frame();
    int exp_addr [$];
    for (int v = 0; v < NV; v++)
      if (m_act[v]) exp_addr.push_back(v * (1 << VOFF_W) + m_pos[v]);
    chk("mix", 32'(mix_out), 32'(model_mix()));
    chk("busy", 32'(busy), 32'(model_busy()));
    if (prev_cyc >= 0) chk("period", 32'(cyc - prev_cyc), SD);
    prev_cyc = cyc;
    chk("rd_count", rd_q.size(), exp_addr.size());
    if (rd_q.size() == exp_addr.size())
      foreach (rd_q[i]) chk("rd_addr", 32'(rd_q[i]), 32'(exp_addr[i]));
    rd_q.delete();
    $display("frame %0d mix=%0d busy=%b", frame_no, $signed(mix_out), busy);
    frame_no++;
    for (int v = 0; v < NV; v++) begin
      if (m_pend[v]) begin
        m_act[v] = 1; m_pos[v] = 0; m_pend[v] = 0;
      end else if (m_act[v] && m_pos[v] == VLEN - 1) begin
        m_act[v] = 0; m_pos[v] = 0;
      end else if (m_act[v]) begin
        m_pos[v]++;
      end
    end
  endtask

  task automatic step(input logic [NV-1:0] new_trig);
    wait_valid();
    check_frame();
    @(negedge clk);
    for (int v = 0; v < NV; v++)
      if (new_trig[v] && !m_trig[v]) m_pend[v] = 1;
    m_trig = new_trig;
    trig   = new_trig;
`ifdef VOICE_SCHED_GAIN_EN
    if (rand_gain) gain = 2*NV'($urandom);
`endif
  endtask

  // Releases reset, then checks first-frame latency and the first (empty) frame.
  task automatic release_and_first_frame();
    int n;
    repeat (2) @(negedge clk);
    chk("rst_hold_valid", 32'(mix_valid), 0);
    rst = 1'b0;
    rd_q.delete();
    prev_cyc = -1;
    for (n = 1; n <= 3 * SD; n++) begin
      @(negedge clk);
      if (mix_valid) break;
    end
    chk("first_latency", n, 2 * NV + 1);
    check_frame();
  endtask

  initial begin
    for (int a = 0; a < (1 << AW); a++) begin
      int v, p;
      v = a >> VOFF_W;
      p = a % (1 << VOFF_W);
      if (v == 0)           rom[a] = 8'h10;
      else if (p < VLEN/2)  rom[a] = 8'h50;
      else                  rom[a] = 8'hA0;
    end
    model_reset();

    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_mix", 32'(mix_out), 0);
    chk("rst_valid", 32'(mix_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rd", 32'(mem_rd), 0);
    chk("rst_addr", 32'(mem_addr), 0);
    release_and_first_frame();

    // Voice 0 alone: constant 16 once it is playing.
    repeat (6) step(4'b0001);

    // Reset lands in CAPT(2) of the following frame.
    repeat (SD - 4) @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 32'(model_busy()));
    chk("pre_rst_mix", 32'(mix_out), 32'(model_mix()));
    rst  = 1'b1;
    trig = '0;
    #1;
    chk("midrst_mix", 32'(mix_out), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_rd", 32'(mem_rd), 0);
    model_reset();
    release_and_first_frame();

    // All voices: saturation high then low.
    repeat (4) step(4'b0001);
    repeat (26) step(4'b1111);

    // Retrigger voice 1 exactly on its last sample.
    step(4'b0000);
    step(4'b0010);
    for (int k = 0; k < 3 * VLEN; k++) begin
      if (m_act[1] && m_pos[1] == VLEN - 3) break;
      step(4'b0010);
    end
    step(4'b0000);
    step(4'b0010);
    repeat (4) step(4'b0010);

    // Random ROM contents and sparse random trigger toggles.
    for (int a = 0; a < (1 << AW); a++) rom[a] = 8'($urandom);
    rand_gain = 1;
    repeat (80) begin
      logic [NV-1:0] t;
      t = m_trig;
      if ($urandom_range(0, 3) == 0) t[$urandom_range(0, NV-1)] ^= 1'b1;
      step(t);
    end
    wait_valid();
    check_frame();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
